pipe_flush_ctr: RTL and testbench
=================================

PIPE_FLUSH_CTR -- requirements
Module: pipe_flush_ctr

Interface
REQ-001 Parameter FLUSH_CYC, default 1, number of flush cycles per redirect (legal 1..15).
REQ-002 Parameter HAS_IRQ, default 1, 0 = irq input ignored (tied inactive internally).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-005 instr_d  in  32  instruction in D stage.
REQ-006 d_valid  in  1  instr_d holds a real instruction (not a bubble).
REQ-007 stall  in  1  hazard unit holding D; blocks acceptance of eret/irq.
REQ-008 irq  in  1  level interrupt request from CP0.
REQ-009 exc_ack  in  1  CP0 has recorded EPC/cause.
REQ-010 br  out  1  D-stage instruction redirects PC.
REQ-011 ext_mode  out  2  immediate extension: 00 zero, 01 sign, 10 upper (lui).
REQ-012 exc_req  out  1  request CP0 to take interrupt.
REQ-013 dclr  out  1  clear D pipeline register.
REQ-014 eclr  out  1  clear E pipeline register.
REQ-015 pc_sel  out  2  00 sequential/branch, 01 handler 0x0000_4180, 10 EPC.

Function
REQ-016 Decode fields: op=instr_d[31:26], rt=instr_d[20:16], funct=instr_d[5:0].
REQ-017 br SHALL be 1 for j(000010), jal(000011), beq(000100), bne(000101), blez(000110), bgtz(000111), op 000001 with rt 00001 (bgez) or 00000 (bltz), op 000000 with funct 001000 (jr) or 001001 (jalr), and eret (op 010000, instr_d[25]=1, funct 011000).
REQ-018 ext_mode SHALL be 01 for lw, lb, lbu, lh, lhu, sb, sh, sw, addi, addiu, slti, sltiu; 10 for lui (001111); 00 otherwise.
REQ-019 br and ext_mode are combinational from instr_d and SHALL be forced to 0 whenever state is not IDLE.
REQ-020 FSM states: IDLE, REQ, FLUSH; reset state IDLE.
REQ-021 IDLE -> REQ when HAS_IRQ && irq && d_valid && !stall.
REQ-022 IDLE -> FLUSH when eret decoded && d_valid && !stall && REQ-021 not met; pc_sel register loads 10.
REQ-023 irq and eret in the same accepting cycle: irq wins, eret not accepted.
REQ-024 REQ: exc_req=1 each cycle; on exc_ack -> FLUSH, pc_sel register loads 01; irq deassertion in REQ does not abort.
REQ-025 exc_ack outside REQ SHALL be ignored.
REQ-026 On FLUSH entry the down-counter loads FLUSH_CYC-1; each FLUSH cycle decrements; at count 0 next state IDLE; FLUSH lasts exactly FLUSH_CYC cycles.
REQ-027 In FLUSH: dclr=1, eclr=1, pc_sel=registered value; stall, irq, eret ignored.
REQ-028 Outside FLUSH: dclr=0, eclr=0, pc_sel=00; exc_req=1 only in REQ.
REQ-029 Counter width SHALL be 4 bits; no wrap below 0.

Reset
REQ-030 On reset (any state, including mid-REQ or mid-FLUSH): state IDLE, counter 0, pc_sel register 00, exc_req=0, dclr=0, eclr=0, pc_sel=00 without waiting for clk.
REQ-031 After reset release, first acceptance possible on the first rising edge with reset low.

Verification
REQ-032 FLUSH_CYC=1, instr_d=0x42000018, d_valid=1, stall=0 -> next cycle dclr=eclr=1, pc_sel=10 for 1 cycle, then IDLE, br=1 in accepting cycle.
REQ-033 FLUSH_CYC=3, irq=1, exc_ack after 2 cycles -> exc_req=1 for 2 cycles, then dclr=eclr=1, pc_sel=01 for exactly 3 cycles, then 0.
REQ-034 irq=1 and eret in D same cycle -> exc_req=1 next cycle, pc_sel never 10.
REQ-035 stall=1 with eret in D for 4 cycles, then stall=0 -> no flush during stall, flush starts cycle after release; d_valid=0 -> no flush.
REQ-036 HAS_IRQ=0, irq=1 -> exc_req stays 0; decode sweep: lui -> 10, sltiu -> 01, ori -> 00, bltz (rt=0) -> br=1.
REQ-037 reset asserted mid-FLUSH (FLUSH_CYC=5, cycle 2) -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/pipe_flush_ctr_if.sv
// D-stage control bundle between the decode/hazard side and the flush controller.
// The controller takes the slave view; the driver of the decode inputs takes the master view.
interface pipe_flush_ctr_if;
  logic [31:0] i_instr_d;
  logic        i_d_valid;
  logic        i_stall;
  logic        i_irq;
  logic        i_exc_ack;
  logic        o_br;
  logic [1:0]  o_ext_mode;
  logic        o_exc_req;
  logic        o_dclr;
  logic        o_eclr;
  logic [1:0]  o_pc_sel;

  modport slave (
    input  i_instr_d, i_d_valid, i_stall, i_irq, i_exc_ack,
    output o_br, o_ext_mode, o_exc_req, o_dclr, o_eclr, o_pc_sel
  );

  modport master (
    output i_instr_d, i_d_valid, i_stall, i_irq, i_exc_ack,
    input  o_br, o_ext_mode, o_exc_req, o_dclr, o_eclr, o_pc_sel
  );
endinterface

// File: rtl/pipe_flush_ctr.sv
// D-stage branch/extension decode plus an IDLE/REQ/FLUSH controller that sequences
// interrupt entry and eret return, clearing D/E for FLUSH_CYC cycles while steering the PC.
module pipe_flush_ctr #(
  parameter int unsigned FLUSH_CYC = 1,
  parameter bit          HAS_IRQ   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  pipe_flush_ctr_if.slave  bus
);
  typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

  localparam logic [3:0] CntLoad = 4'(FLUSH_CYC - 1);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic       r_exc_req;
  logic       r_flush;
  logic [1:0] r_pc_sel;

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic       w_eret;
  logic       w_br;
  logic [1:0] w_ext;
  logic       w_irq;
  logic       w_accept;

  assign w_op     = bus.i_instr_d[31:26];
  assign w_rt     = bus.i_instr_d[20:16];
  assign w_funct  = bus.i_instr_d[5:0];
  assign w_eret   = (w_op == 6'b010000) && bus.i_instr_d[25] && (w_funct == 6'b011000);
  assign w_irq    = HAS_IRQ && bus.i_irq;
  assign w_accept = bus.i_d_valid && !bus.i_stall;

  always_comb begin
    w_br  = 1'b0;
    w_ext = 2'b00;
    case (w_op)
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: w_br = 1'b1;
      6'b000001: w_br = (w_rt == 5'b00000) || (w_rt == 5'b00001);
      6'b000000: w_br = (w_funct == 6'b001000) || (w_funct == 6'b001001);
      default:   w_br = 1'b0;
    endcase
    if (w_eret) w_br = 1'b1;
    case (w_op)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011,
      6'b001000, 6'b001001, 6'b001010, 6'b001011: w_ext = 2'b01;
      6'b001111: w_ext = 2'b10;
      default:   w_ext = 2'b00;
    endcase
  end

  // Decode is only meaningful while the pipeline is running normally.
  assign bus.o_br       = (r_state == StIdle) && w_br;
  assign bus.o_ext_mode = (r_state == StIdle) ? w_ext : 2'b00;
  assign bus.o_exc_req  = r_exc_req;
  assign bus.o_dclr     = r_flush;
  assign bus.o_eclr     = r_flush;
  assign bus.o_pc_sel   = r_pc_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_exc_req <= 1'b0;
      r_flush   <= 1'b0;
      r_pc_sel  <= 2'b00;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Interrupt has priority over an eret sitting in D on the same cycle.
          if (w_irq && w_accept) begin
            r_state   <= StReq;
            r_exc_req <= 1'b1;
          end else if (w_eret && w_accept) begin
            r_state  <= StFlush;
            r_cnt    <= CntLoad;
            r_flush  <= 1'b1;
            r_pc_sel <= 2'b10;
          end
        end
        StReq: begin
          if (bus.i_exc_ack) begin
            r_state   <= StFlush;
            r_cnt     <= CntLoad;
            r_exc_req <= 1'b0;
            r_flush   <= 1'b1;
            r_pc_sel  <= 2'b01;
          end
        end
        StFlush: begin
          if (r_cnt == 4'd0) begin
            r_state  <= StIdle;
            r_flush  <= 1'b0;
            r_pc_sel <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_cnt     <= 4'd0;
          r_exc_req <= 1'b0;
          r_flush   <= 1'b0;
          r_pc_sel  <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_flush_ctr.sv
// Drives three controller variants (FLUSH_CYC 1/3/5; the last without irq) from shared inputs
// and compares every output against a counter-based reference model.
module tb_pipe_flush_ctr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] t_instr = 32'h0;
  logic        t_dv = 1'b0;
  logic        t_stall = 1'b0;
  logic        t_irq = 1'b0;
  logic        t_ack = 1'b0;

  always #5 clk = ~clk;

  pipe_flush_ctr_if if0 ();
  pipe_flush_ctr_if if1 ();
  pipe_flush_ctr_if if2 ();

  assign if0.i_instr_d = t_instr;
  assign if0.i_d_valid = t_dv;
  assign if0.i_stall   = t_stall;
  assign if0.i_irq     = t_irq;
  assign if0.i_exc_ack = t_ack;
  assign if1.i_instr_d = t_instr;
  assign if1.i_d_valid = t_dv;
  assign if1.i_stall   = t_stall;
  assign if1.i_irq     = t_irq;
  assign if1.i_exc_ack = t_ack;
  assign if2.i_instr_d = t_instr;
  assign if2.i_d_valid = t_dv;
  assign if2.i_stall   = t_stall;
  assign if2.i_irq     = t_irq;
  assign if2.i_exc_ack = t_ack;

  pipe_flush_ctr #(.FLUSH_CYC(1), .HAS_IRQ(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_flush_ctr #(.FLUSH_CYC(3), .HAS_IRQ(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_flush_ctr #(.FLUSH_CYC(5), .HAS_IRQ(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // Observed outputs packed as {br, ext_mode, exc_req, dclr, eclr, pc_sel}.
  logic [7:0] obs [3];
  assign obs[0] = {if0.o_br, if0.o_ext_mode, if0.o_exc_req, if0.o_dclr, if0.o_eclr, if0.o_pc_sel};
  assign obs[1] = {if1.o_br, if1.o_ext_mode, if1.o_exc_req, if1.o_dclr, if1.o_eclr, if1.o_pc_sel};
  assign obs[2] = {if2.o_br, if2.o_ext_mode, if2.o_exc_req, if2.o_dclr, if2.o_eclr, if2.o_pc_sel};

  // Reference model: pending-request flag plus remaining flush cycles and flush target.
  int         fc_of [3] = '{1, 3, 5};
  bit         hi_of [3] = '{1'b1, 1'b1, 1'b0};
  bit         m_req [3];
  int         m_left [3];
  logic [1:0] m_tgt [3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit ref_eret(input logic [31:0] w);
    return w[31:26] == 6'b010000 && w[25] && w[5:0] == 6'b011000;
  endfunction

  function automatic bit ref_br(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) return 1'b1;
    if (op == 6'd1 && w[20:16] inside {5'd0, 5'd1}) return 1'b1;
    if (op == 6'd0 && w[5:0] inside {6'd8, 6'd9}) return 1'b1;
    return ref_eret(w);
  endfunction

  function automatic logic [1:0] ref_ext(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                   6'h08, 6'h09, 6'h0A, 6'h0B}) return 2'b01;
    if (op == 6'h0F) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_out(input int k);
    bit idle;
    bit fl;
    idle = !m_req[k] && m_left[k] == 0;
    fl   = m_left[k] > 0;
    return {idle && ref_br(t_instr), idle ? ref_ext(t_instr) : 2'b00, m_req[k],
            fl, fl, fl ? m_tgt[k] : 2'b00};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_req[k]  = 1'b0;
      m_left[k] = 0;
      m_tgt[k]  = 2'b00;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (m_left[k] > 0) begin
        m_left[k]--;
      end else if (m_req[k]) begin
        if (t_ack) begin
          m_req[k]  = 1'b0;
          m_left[k] = fc_of[k];
          m_tgt[k]  = 2'b01;
        end
      end else if (hi_of[k] && t_irq && t_dv && !t_stall) begin
        m_req[k] = 1'b1;
      end else if (ref_eret(t_instr) && t_dv && !t_stall) begin
        m_left[k] = fc_of[k];
        m_tgt[k]  = 2'b10;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      exp = ref_out(k);
      n_checks++;
      assert (obs[k] === exp) n_pass++;
      else $error("FAIL %s u%0d observed=%b expected=%b", tag, k, obs[k], exp);
    end
  endtask

  // Called at posedge+1 with inputs already set: check, clock, advance the model.
  task automatic step(input string tag);
    #1;
    check(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain(input int n);
    t_instr = 32'h0;
    t_irq   = 1'b0;
    t_ack   = 1'b0;
    t_stall = 1'b0;
    for (int i = 0; i < n; i++) step("drain");
  endtask

  logic [5:0] op_pool [12] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h07, 6'h09,
                               6'h0B, 6'h0D, 6'h0F, 6'h10, 6'h23, 6'h2B};

  initial begin
    model_reset();
    #1;
    check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // eret accepted on first edge after reset release.
    t_dv    = 1'b1;
    t_instr = 32'h4200_0018;
    step("eret_accept");
    t_instr = 32'h0;
    step("eret_flush");
    drain(6);

    // Interrupt entry; irq drops while waiting, ack after two REQ cycles.
    t_irq = 1'b1;
    step("irq_accept");
    t_irq = 1'b0;
    step("req_c1");
    t_ack = 1'b1;
    step("req_c2_ack");
    t_ack = 1'b0;
    drain(6);

    // irq and eret together: irq wins where irq is enabled.
    t_irq   = 1'b1;
    t_instr = 32'h4200_0018;
    step("irq_eret_same");
    t_irq   = 1'b0;
    t_instr = 32'h0;
    step("irq_eret_req");
    t_ack = 1'b1;
    step("irq_eret_ack");
    drain(6);

    // Stalled eret is held off until stall drops.
    t_instr = 32'h4200_0018;
    t_stall = 1'b1;
    for (int i = 0; i < 4; i++) step("eret_stalled");
    t_stall = 1'b0;
    step("eret_release");
    drain(6);

    // Bubble carrying eret bits, and exc_ack while idle, both ignored.
    t_dv    = 1'b0;
    t_instr = 32'h4200_0018;
    step("eret_bubble");
    step("eret_bubble2");
    t_dv    = 1'b1;
    t_instr = 32'h0;
    t_ack   = 1'b1;
    step("ack_idle");
    t_ack = 1'b0;
    step("ack_idle_after");

    // Decode sweep.
    t_instr = 32'h3C01_0001; step("dec_lui");
    t_instr = 32'h2C22_0005; step("dec_sltiu");
    t_instr = 32'h3422_0005; step("dec_ori");
    t_instr = 32'h0420_0003; step("dec_bltz");
    t_instr = 32'h0421_0003; step("dec_bgez");
    t_instr = 32'h0422_0003; step("dec_regimm_other");
    t_instr = 32'h03E0_0008; step("dec_jr");
    t_instr = 32'h1022_0004; step("dec_beq");
    t_instr = 32'h8C22_0000; step("dec_lw");
    t_instr = 32'h4000_0018; step("dec_eret_no_co");

    // Reset mid-FLUSH, away from any clock edge.
    t_instr = 32'h4200_0018;
    step("pre_rst_accept");
    t_instr = 32'h3C01_0001;
    step("pre_rst_f1");
    step("pre_rst_f2");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst");
    @(posedge clk);
    #1;
    check("rst_held");
    rst = 1'b0;
    step("post_rst_idle");
    t_instr = 32'h0;
    step("post_rst_idle2");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) t_instr = 32'h4200_0018;
      else t_instr = {op_pool[$urandom_range(11)], 26'($urandom)};
      t_dv    = $urandom_range(3) != 0;
      t_stall = $urandom_range(3) == 0;
      t_irq   = $urandom_range(7) == 0;
      t_ack   = $urandom_range(2) == 0;
      step("random");
    end
    drain(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
